// File: rtl/router_reg.sv
// Datapath register stage of the 1x3 packet router: captures the header, routes
// bytes toward the FIFOs, accumulates packet parity and reports mismatches.
module router_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pkt_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_full,
  input  logic                  detect_add,
  input  logic                  lfd_state,
  input  logic                  ld_state,
  input  logic                  full_state,
  input  logic                  laf_state,
  input  logic                  rst_int_reg,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  parity_done,
  output logic                  low_pkt_valid,
  output logic                  err
);

  logic [DATA_WIDTH-1:0] header_q, header_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] int_par_q, int_par_d;
  logic [DATA_WIDTH-1:0] pkt_par_q, pkt_par_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  parity_done_q, parity_done_d;
  logic                  low_pkt_valid_q, low_pkt_valid_d;
  logic                  err_q, err_d;

  function automatic logic parity_mismatch(input logic [DATA_WIDTH-1:0] computed,
                                           input logic [DATA_WIDTH-1:0] received);
    return (computed != received);
  endfunction

  // Next-state logic; full_state stalls every register of the stage.
  always_comb begin
    header_d        = header_q;
    hold_d          = hold_q;
    int_par_d       = int_par_q;
    pkt_par_d       = pkt_par_q;
    dout_d          = dout_q;
    parity_done_d   = parity_done_q;
    low_pkt_valid_d = low_pkt_valid_q;
    err_d           = err_q;
    if (full_state) begin
      header_d = header_q;
    end else begin
      if (detect_add && pkt_valid && (data_in[1:0] != 2'b11)) begin
        header_d = data_in;
      end else begin
        header_d = header_q;
      end

      if (lfd_state) begin
        dout_d = header_q;
      end else if (ld_state && !fifo_full) begin
        dout_d = data_in;
      end else if (laf_state) begin
        dout_d = hold_q;
      end else begin
        dout_d = dout_q;
      end

      if (ld_state && fifo_full) begin
        hold_d = data_in;
      end else begin
        hold_d = hold_q;
      end

      if (detect_add) begin
        int_par_d = {DATA_WIDTH{1'b0}};
      end else if (lfd_state) begin
        int_par_d = int_par_q ^ header_q;
      end else if (ld_state && pkt_valid) begin
        int_par_d = int_par_q ^ data_in;
      end else begin
        int_par_d = int_par_q;
      end

      if (ld_state && !pkt_valid) begin
        pkt_par_d = data_in;
      end else begin
        pkt_par_d = pkt_par_q;
      end

      if (ld_state && !pkt_valid) begin
        low_pkt_valid_d = 1'b1;
      end else if (rst_int_reg) begin
        low_pkt_valid_d = 1'b0;
      end else begin
        low_pkt_valid_d = low_pkt_valid_q;
      end

      // A parity byte parked in hold_reg completes only once it is replayed in laf_state.
      if (detect_add) begin
        parity_done_d = 1'b0;
      end else if ((ld_state && !pkt_valid && !fifo_full) ||
                   (laf_state && low_pkt_valid_q && !parity_done_q)) begin
        parity_done_d = 1'b1;
      end else begin
        parity_done_d = parity_done_q;
      end

      if (rst_int_reg && parity_done_q) begin
        err_d = parity_mismatch(int_par_q, pkt_par_q);
      end else if (detect_add && pkt_valid) begin
        err_d = 1'b0;
      end else begin
        err_d = err_q;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      header_q        <= {DATA_WIDTH{1'b0}};
      hold_q          <= {DATA_WIDTH{1'b0}};
      int_par_q       <= {DATA_WIDTH{1'b0}};
      pkt_par_q       <= {DATA_WIDTH{1'b0}};
      dout_q          <= {DATA_WIDTH{1'b0}};
      parity_done_q   <= 1'b0;
      low_pkt_valid_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      header_q        <= header_d;
      hold_q          <= hold_d;
      int_par_q       <= int_par_d;
      pkt_par_q       <= pkt_par_d;
      dout_q          <= dout_d;
      parity_done_q   <= parity_done_d;
      low_pkt_valid_q <= low_pkt_valid_d;
      err_q           <= err_d;
    end
  end

  assign dout          = dout_q;
  assign parity_done   = parity_done_q;
  assign low_pkt_valid = low_pkt_valid_q;
  assign err           = err_q;

endmodule

// File: tb/tb_router_reg.sv
// Directed bench for router_reg: a packet-level reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_router_reg;

  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_DA   = 6'b100000;
  localparam logic [5:0] S_LFD  = 6'b010000;
  localparam logic [5:0] S_LD   = 6'b001000;
  localparam logic [5:0] S_FULL = 6'b000100;
  localparam logic [5:0] S_LAF  = 6'b000010;
  localparam logic [5:0] S_RIR  = 6'b000001;

  logic       clock = 1'b0;
  logic       reset, pkt_valid, fifo_full;
  logic       detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg;
  logic [7:0] data_in, dout;
  logic       parity_done, low_pkt_valid, err;

  int checks = 0;
  int failures = 0;

  router_reg #(.DATA_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .full_state(full_state), .laf_state(laf_state),
    .rst_int_reg(rst_int_reg), .dout(dout), .parity_done(parity_done),
    .low_pkt_valid(low_pkt_valid), .err(err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes that count toward parity are kept as a list and
  // folded only when the packet is checked.
  logic [7:0] m_header = 8'h00, m_hold = 8'h00, m_par_byte = 8'h00, m_dout = 8'h00;
  logic       m_pd = 1'b0, m_lpv = 1'b0, m_err = 1'b0, started = 1'b0;
  logic [7:0] m_bytes[$];

  function automatic logic [7:0] fold(input logic [7:0] q[$]);
    logic [7:0] acc = 8'h00;
    foreach (q[i]) acc = acc ^ q[i];
    return acc;
  endfunction

  always @(posedge clock) begin
    started = 1'b1;
    if (reset) begin
      m_header = 8'h00; m_hold = 8'h00; m_par_byte = 8'h00; m_dout = 8'h00;
      m_pd = 1'b0; m_lpv = 1'b0; m_err = 1'b0;
      m_bytes.delete();
    end else if (!full_state) begin
      if (detect_add) begin
        m_bytes.delete();
        m_pd = 1'b0;
        if (pkt_valid) begin
          m_err = 1'b0;
          if (data_in[1:0] != 2'b11) m_header = data_in;
        end
      end
      if (lfd_state) begin
        m_dout = m_header;
        m_bytes.push_back(m_header);
      end
      if (ld_state) begin
        if (fifo_full) m_hold = data_in;
        else m_dout = data_in;
        if (pkt_valid) m_bytes.push_back(data_in);
        else begin
          m_par_byte = data_in;
          m_lpv = 1'b1;
          if (!fifo_full) m_pd = 1'b1;
        end
      end
      if (laf_state) begin
        m_dout = m_hold;
        if (m_lpv) m_pd = 1'b1;
      end
      if (rst_int_reg) begin
        if (m_pd) m_err = (fold(m_bytes) != m_par_byte);
        m_lpv = 1'b0;
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clock) begin
    if (started) begin
      chk("model_dout", dout, m_dout);
      chk("model_parity_done", {7'd0, parity_done}, {7'd0, m_pd});
      chk("model_low_pkt_valid", {7'd0, low_pkt_valid}, {7'd0, m_lpv});
      chk("model_err", {7'd0, err}, {7'd0, m_err});
    end
  end

  task automatic step(input logic [5:0] st, input logic pv, input logic [7:0] d,
                      input logic ff, input logic rs);
    {detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg} = st;
    pkt_valid = pv;
    data_in   = d;
    fifo_full = ff;
    reset     = rs;
    @(posedge clock);
    #1;
  endtask

  initial begin
    {detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg} = S_NONE;
    pkt_valid = 1'b0; data_in = 8'h00; fifo_full = 1'b0; reset = 1'b1;
    step(S_NONE, 1'b0, 8'h00, 1'b0, 1'b1);
    step(S_NONE, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("reset_dout", dout, 8'h00);
    chk("reset_flags", {5'd0, parity_done, low_pkt_valid, err}, 8'h00);

    // Normal packet
    step(S_DA,  1'b1, 8'h0D, 1'b0, 1'b0);
    step(S_LFD, 1'b1, 8'h11, 1'b0, 1'b0);
    chk("good_hdr_dout", dout, 8'h0D);
    step(S_LD,  1'b1, 8'h11, 1'b0, 1'b0); chk("good_d1", dout, 8'h11);
    step(S_LD,  1'b1, 8'h22, 1'b0, 1'b0); chk("good_d2", dout, 8'h22);
    step(S_LD,  1'b1, 8'h33, 1'b0, 1'b0); chk("good_d3", dout, 8'h33);
    step(S_LD,  1'b0, 8'h0D, 1'b0, 1'b0);
    chk("good_par_dout", dout, 8'h0D);
    chk("good_pd_lpv", {6'd0, parity_done, low_pkt_valid}, 8'h03);
    step(S_RIR, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("good_err", {7'd0, err}, 8'h00);
    step(S_NONE, 1'b0, 8'h00, 1'b0, 1'b0);

    // Bad parity, then err clears on the next header
    step(S_DA,  1'b1, 8'h0D, 1'b0, 1'b0);
    step(S_LFD, 1'b1, 8'h11, 1'b0, 1'b0);
    step(S_LD,  1'b1, 8'h11, 1'b0, 1'b0);
    step(S_LD,  1'b1, 8'h22, 1'b0, 1'b0);
    step(S_LD,  1'b1, 8'h33, 1'b0, 1'b0);
    step(S_LD,  1'b0, 8'hFF, 1'b0, 1'b0);
    step(S_RIR, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("bad_err_set", {7'd0, err}, 8'h01);
    step(S_NONE, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("bad_err_holds", {7'd0, err}, 8'h01);

    // Full during payload
    step(S_DA,  1'b1, 8'h0D, 1'b0, 1'b0);
    chk("bad_err_clear", {7'd0, err}, 8'h00);
    step(S_LFD, 1'b1, 8'h11, 1'b0, 1'b0);
    step(S_LD,  1'b1, 8'h11, 1'b0, 1'b0);
    step(S_LD,  1'b1, 8'h22, 1'b1, 1'b0); chk("full_hold_dout", dout, 8'h11);
    step(S_FULL, 1'b1, 8'h33, 1'b1, 1'b0);
    step(S_FULL, 1'b1, 8'h33, 1'b1, 1'b0); chk("full_stall_dout", dout, 8'h11);
    step(S_LAF, 1'b1, 8'h33, 1'b0, 1'b0); chk("full_laf_dout", dout, 8'h22);
    step(S_LD,  1'b1, 8'h33, 1'b0, 1'b0);
    step(S_LD,  1'b0, 8'h0D, 1'b0, 1'b0);
    step(S_RIR, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("full_err", {6'd0, parity_done, err}, 8'h02);

    // Full on the parity byte
    step(S_DA,  1'b1, 8'h0D, 1'b0, 1'b0);
    step(S_LFD, 1'b1, 8'h11, 1'b0, 1'b0);
    step(S_LD,  1'b1, 8'h11, 1'b0, 1'b0);
    step(S_LD,  1'b1, 8'h22, 1'b0, 1'b0);
    step(S_LD,  1'b1, 8'h33, 1'b0, 1'b0);
    step(S_LD,  1'b0, 8'h0D, 1'b1, 1'b0);
    chk("pfull_pd_lpv", {6'd0, parity_done, low_pkt_valid}, 8'h01);
    step(S_FULL, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("pfull_stall_pd", {7'd0, parity_done}, 8'h00);
    step(S_LAF, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("pfull_laf_pd", {7'd0, parity_done}, 8'h01);
    chk("pfull_laf_dout", dout, 8'h0D);
    step(S_RIR, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("pfull_err", {7'd0, err}, 8'h00);

    // Invalid address keeps the previous header
    step(S_DA,  1'b1, 8'h07, 1'b0, 1'b0);
    step(S_LFD, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("badaddr_hdr", dout, 8'h0D);

    // Reset mid-packet, then a fresh packet
    step(S_DA,  1'b1, 8'h05, 1'b0, 1'b0);
    step(S_LFD, 1'b1, 8'hAA, 1'b0, 1'b0);
    step(S_LD,  1'b1, 8'hAA, 1'b0, 1'b0);
    step(S_LD,  1'b0, 8'hAF, 1'b0, 1'b1);
    chk("rst_dout", dout, 8'h00);
    chk("rst_flags", {5'd0, parity_done, low_pkt_valid, err}, 8'h00);
    step(S_DA,  1'b1, 8'h05, 1'b0, 1'b0);
    step(S_LFD, 1'b1, 8'hAA, 1'b0, 1'b0); chk("post_hdr", dout, 8'h05);
    step(S_LD,  1'b1, 8'hAA, 1'b0, 1'b0);
    step(S_LD,  1'b0, 8'hAF, 1'b0, 1'b0);
    step(S_RIR, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("post_err", {6'd0, parity_done, err}, 8'h02);
    step(S_NONE, 1'b0, 8'h00, 1'b0, 1'b0);
    step(S_NONE, 1'b0, 8'h00, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
